// File: rtl/matmul_pkg.sv
// Shared constants for the matmul index/address generators.
// Reset value, default address width and wrap targets.
package matmul_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned STEP_CNT_RST_VAL = 0;

  typedef enum logic {
    WRAP_TO_ZERO  = 1'b0,
    WRAP_TO_LIMIT = 1'b1
  } wrap_mode_e;

  // Overflow lands at 0, underflow lands back on the limit.
  localparam wrap_mode_e STEP_CNT_UP_WRAP = WRAP_TO_ZERO;
  localparam wrap_mode_e STEP_CNT_DN_WRAP = WRAP_TO_LIMIT;

endpackage

// File: rtl/step_wrap_adder.sv
// Next-value and wrap flag for a stepped, limit-wrapped counter.
// Subtract path exists only with STEP_CNT_DEC_EN defined.
module step_wrap_adder
  import matmul_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] inc_nxt_o,
  output logic             inc_wrap_o
`ifdef STEP_CNT_DEC_EN
  ,
  output logic [WIDTH-1:0] dec_nxt_o,
  output logic             dec_wrap_o
`endif
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] up_tgt;

  // Carry bit kept so limit=all-ones still wraps.
  assign sum        = {1'b0, cur_i} + {1'b0, step_i};
  assign inc_wrap_o = sum > {1'b0, limit_i};
  assign up_tgt     = (STEP_CNT_UP_WRAP == WRAP_TO_ZERO)
                    ? '0 : limit_i;
  assign inc_nxt_o  = inc_wrap_o ? up_tgt : sum[WIDTH-1:0];

`ifdef STEP_CNT_DEC_EN
  logic [WIDTH-1:0] dn_tgt;

  assign dec_wrap_o = cur_i < step_i;
  assign dn_tgt     = (STEP_CNT_DN_WRAP == WRAP_TO_LIMIT)
                    ? limit_i : '0;
  assign dec_nxt_o  = dec_wrap_o ? dn_tgt : cur_i - step_i;
`endif

endmodule

// File: rtl/step_counter_register.sv
// Loadable stepped counter with limit wrap and one-cycle wrap pulse.
// Define STEP_CNT_DEC_EN to add the dec port and down-count path.
module step_counter_register
  import matmul_pkg::*;
#(
  parameter int unsigned      WIDTH   = ADDR_W,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(STEP_CNT_RST_VAL)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             inc,
`ifdef STEP_CNT_DEC_EN
  input  logic             dec,
`endif
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] data_out,
  output logic             at_limit,
  output logic             wrap
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_nxt;
  logic             inc_wrap;
`ifdef STEP_CNT_DEC_EN
  logic [WIDTH-1:0] dec_nxt;
  logic             dec_wrap;
`endif

  step_wrap_adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .cur_i     (data_q),
    .step_i    (step),
    .limit_i   (limit),
    .inc_nxt_o (inc_nxt),
    .inc_wrap_o(inc_wrap)
`ifdef STEP_CNT_DEC_EN
    ,
    .dec_nxt_o (dec_nxt),
    .dec_wrap_o(dec_wrap)
`endif
  );

  always_comb begin
    data_d = data_q;
    wrap_d = 1'b0;
    if (clear) begin
      data_d = '0;
    end else if (load_enable) begin
      data_d = data_in;
    end else if (inc) begin
      data_d = inc_nxt;
      wrap_d = inc_wrap;
`ifdef STEP_CNT_DEC_EN
    end else if (dec) begin
      data_d = dec_nxt;
      wrap_d = dec_wrap;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      data_q <= data_d;
      wrap_q <= wrap_d;
    end
  end

  assign data_out = data_q;
  assign wrap     = wrap_q;
  assign at_limit = data_q == limit;

endmodule

// File: tb/tb_step_counter_register.sv
// Randomized and directed checks of step_counter_register.
// Main DUT tracked by a behavioural model; nested pair checked by hand.
module tb_step_counter_register;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear, load_enable, inc;
  logic [W-1:0] data_in, step, limit;
  logic [W-1:0] data_out;
  logic         at_limit, wrap;
`ifdef STEP_CNT_DEC_EN
  logic         dec;
`endif

  logic         n_clr, n_inc;
  logic [W-1:0] in_q, out_q;
  logic         in_at, out_at, in_wrap, out_wrap;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mv;
  logic         mw;

  always #5 clk = ~clk;

  step_counter_register #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .load_enable(load_enable),
    .data_in    (data_in),
    .inc        (inc),
`ifdef STEP_CNT_DEC_EN
    .dec        (dec),
`endif
    .step       (step),
    .limit      (limit),
    .data_out   (data_out),
    .at_limit   (at_limit),
    .wrap       (wrap)
  );

  step_counter_register #(.WIDTH(W)) u_inner (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (n_clr),
    .load_enable(1'b0),
    .data_in    (16'h0),
    .inc        (n_inc),
`ifdef STEP_CNT_DEC_EN
    .dec        (1'b0),
`endif
    .step       (16'd1),
    .limit      (16'd3),
    .data_out   (in_q),
    .at_limit   (in_at),
    .wrap       (in_wrap)
  );

  step_counter_register #(.WIDTH(W)) u_outer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (n_clr),
    .load_enable(1'b0),
    .data_in    (16'h0),
    .inc        (in_wrap),
`ifdef STEP_CNT_DEC_EN
    .dec        (1'b0),
`endif
    .step       (16'd1),
    .limit      (16'd2),
    .data_out   (out_q),
    .at_limit   (out_at),
    .wrap       (out_wrap)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the stated priority rules.
  always @(posedge clk or negedge reset_n) begin
    int s;
    if (!reset_n) begin
      mv = '0;
      mw = 1'b0;
    end else if (clear) begin
      mv = '0;
      mw = 1'b0;
    end else if (load_enable) begin
      mv = data_in;
      mw = 1'b0;
    end else if (inc) begin
      s = int'(mv) + int'(step);
      if (s > int'(limit)) begin
        mv = '0;
        mw = 1'b1;
      end else begin
        mv = W'(s);
        mw = 1'b0;
      end
`ifdef STEP_CNT_DEC_EN
    end else if (dec) begin
      if (int'(mv) < int'(step)) begin
        mv = limit;
        mw = 1'b1;
      end else begin
        mv = W'(int'(mv) - int'(step));
        mw = 1'b0;
      end
`endif
    end else begin
      mw = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_data", data_out, mv);
      chk("model_wrap", wrap, mw);
      chk("model_at_limit", at_limit, mv == limit);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; load_enable = 0; inc = 0;
`ifdef STEP_CNT_DEC_EN
    dec = 0;
`endif
  endtask

  task automatic lit(input string n, input logic [W-1:0] d,
                     input logic w);
    chk({n, "_data"}, data_out, d);
    chk({n, "_wrap"}, wrap, w);
  endtask

  initial begin
    logic [W-1:0] seq_d [5];
    logic         seq_w [5];
    logic [W-1:0] outer_seq[$];
    int           in_wraps, out_wraps;

    reset_n = 1'b0;
    idle();
    data_in = '0; step = 16'd1; limit = 16'hFFFF;
    n_clr = 0; n_inc = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick();
    lit("reset", 16'h0, 1'b0);

    // Async reset in the middle of a count.
    data_in = 16'h0042; load_enable = 1; tick(); idle();
    lit("preload", 16'h0042, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    lit("async_rst", 16'h0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    lit("rst_release", 16'h0, 1'b0);

    // limit 9, step 3
    limit = 16'd9; step = 16'd3; inc = 1;
    seq_d = '{16'd3, 16'd6, 16'd9, 16'd0, 16'd3};
    seq_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      lit($sformatf("seq%0d", i), seq_d[i], seq_w[i]);
      chk($sformatf("seq%0d_atlim", i), at_limit, i == 2);
    end
    idle();

    // Priority
    clear = 1; load_enable = 1; inc = 1; data_in = 16'h1234;
    tick();
    lit("prio_clear", 16'h0, 1'b0);
    clear = 0;
    tick();
    lit("prio_load", 16'h1234, 1'b0);
    load_enable = 0; limit = 16'hFFFF; step = 16'd1;
    tick();
    lit("prio_inc", 16'h1235, 1'b0);
    idle();

    // Carry wrap at full range
    data_in = 16'hFFFF; load_enable = 1; tick(); idle();
    chk("full_atlim", at_limit, 1'b1);
    inc = 1; tick(); idle();
    lit("carry_wrap", 16'h0, 1'b1);
    tick();
    lit("wrap_drop", 16'h0, 1'b0);

    // Loaded above limit
    limit = 16'h0010; data_in = 16'h0020; load_enable = 1; tick();
    lit("load_over", 16'h0020, 1'b0);
    load_enable = 0; inc = 1; tick(); idle();
    lit("over_wrap", 16'h0, 1'b1);

    // step 0 holds; limit 0 always wraps
    data_in = 16'd5; limit = 16'd9; step = 16'd0;
    load_enable = 1; tick(); load_enable = 0; inc = 1; tick();
    lit("step0", 16'd5, 1'b0);
    limit = 16'd0; step = 16'd4; tick();
    lit("lim0_a", 16'd0, 1'b1);
    tick();
    lit("lim0_b", 16'd0, 1'b1);
    idle();

`ifdef STEP_CNT_DEC_EN
    limit = 16'd7; step = 16'd2; data_in = 16'd1;
    load_enable = 1; tick(); load_enable = 0;
    dec = 1; tick();
    lit("dec_wrap", 16'd7, 1'b1);
    tick();
    lit("dec_sub", 16'd5, 1'b0);
    inc = 1; tick();
    lit("inc_over_dec", 16'd7, 1'b0);
    idle();
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      clear       = ($urandom_range(0, 39) == 0);
      load_enable = ($urandom_range(0, 15) == 0);
      inc         = ($urandom_range(0, 3) != 0);
`ifdef STEP_CNT_DEC_EN
      dec         = ($urandom_range(0, 2) == 0);
`endif
      data_in = W'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = W'($urandom_range(0, 40));
      step = W'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) step = W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: limit = 16'd0;
          1: limit = 16'hFFFF;
          2: limit = W'($urandom);
          default: limit = W'($urandom_range(1, 30));
        endcase
      end
      tick();
    end
    idle();

    // Nested loops: inner 0..3 drives outer 0..2
    n_clr = 1; tick(); n_clr = 0;
    in_wraps = 0; out_wraps = 0;
    outer_seq.push_back(out_q);
    n_inc = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) n_inc = 0;
      tick();
      if (in_wrap) in_wraps++;
      if (out_wrap) out_wraps++;
      if (out_q != outer_seq[$]) outer_seq.push_back(out_q);
    end
    chk("nest_in_wraps", in_wraps, 3);
    chk("nest_out_wraps", out_wraps, 1);
    chk("nest_len", outer_seq.size(), 4);
    if (outer_seq.size() == 4) begin
      chk("nest_o0", outer_seq[0], 0);
      chk("nest_o1", outer_seq[1], 1);
      chk("nest_o2", outer_seq[2], 2);
      chk("nest_o3", outer_seq[3], 0);
    end
    chk("nest_inner_end", in_q, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
